// File: rtl/flash_sample_streamer.sv
// Streams 32-bit flash words over Avalon-MM as 16-bit samples (normal / fast / slow playback).
// Optional macro STREAMER_DIV64_EN scales each sample by 1/64 (arithmetic shift right by 6).
module flash_sample_streamer #(
    parameter int FLASH_AW  = 23,
    parameter int SAMPLE_W  = 16,
    parameter int NUM_WORDS = 2097152
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          mode,
    output logic                busy,
    output logic                done,
    output logic                flash_mem_read,
    output logic [FLASH_AW-1:0] flash_mem_address,
    output logic                flash_mem_burstcount,
    input  logic                flash_mem_waitrequest,
    input  logic [31:0]         flash_mem_readdata,
    input  logic                flash_mem_readdatavalid,
    output logic                sample_valid,
    input  logic                sample_ready,
    output logic [SAMPLE_W-1:0] sample_data
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_EMIT_LO,
        S_EMIT_HI,
        S_FIN
    } state_t;

    localparam logic [FLASH_AW-1:0] LAST_W = FLASH_AW'(NUM_WORDS - 1);

    state_t              state;
    logic [FLASH_AW-1:0] w;
    logic [1:0]          mode_q;
    logic [SAMPLE_W-1:0] hi_q;
    logic                rep;
    logic                xfer;
    logic                slow;
    logic                fast;
    logic                half_done;
    logic                word_done;

    function automatic logic [SAMPLE_W-1:0] shape(input logic [SAMPLE_W-1:0] half);
`ifdef STREAMER_DIV64_EN
        shape = $unsigned($signed(half) >>> 6);
`else
        shape = half;
`endif
    endfunction

    assign flash_mem_burstcount = 1'b1;
    assign flash_mem_address    = w;

    assign xfer = sample_valid & sample_ready;
    assign slow = (mode_q == 2'b10);
    assign fast = (mode_q == 2'b01);
    // In slow mode the first transfer of a half only arms the repeat.
    assign half_done = xfer & ~(slow & ~rep);
    assign word_done = half_done & ((state == S_EMIT_HI) | ((state == S_EMIT_LO) & fast));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            w              <= '0;
            mode_q         <= 2'b00;
            hi_q           <= '0;
            rep            <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            flash_mem_read <= 1'b0;
            sample_valid   <= 1'b0;
            sample_data    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state          <= S_REQ;
                        w              <= '0;
                        mode_q         <= mode;
                        rep            <= 1'b0;
                        busy           <= 1'b1;
                        flash_mem_read <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (!flash_mem_waitrequest) begin
                        flash_mem_read <= 1'b0;
                        state          <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (flash_mem_readdatavalid) begin
                        hi_q         <= flash_mem_readdata[2*SAMPLE_W-1:SAMPLE_W];
                        sample_data  <= shape(flash_mem_readdata[SAMPLE_W-1:0]);
                        sample_valid <= 1'b1;
                        rep          <= 1'b0;
                        state        <= S_EMIT_LO;
                    end
                end
                S_EMIT_LO, S_EMIT_HI: begin
                    if (xfer) begin
                        if (!half_done) begin
                            rep <= 1'b1;
                        end else if (word_done) begin
                            sample_valid <= 1'b0;
                            rep          <= 1'b0;
                            if (w != LAST_W) begin
                                w              <= w + 1'b1;
                                flash_mem_read <= 1'b1;
                                state          <= S_REQ;
                            end else begin
                                done  <= 1'b1;
                                state <= S_FIN;
                            end
                        end else begin
                            rep         <= 1'b0;
                            sample_data <= shape(hi_q);
                            state       <= S_EMIT_HI;
                        end
                    end
                end
                S_FIN: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_flash_sample_streamer.sv
// Directed bench for flash_sample_streamer with NUM_WORDS=2; flash slave and consumer driven by hand.
// Sample expectations follow STREAMER_DIV64_EN so the same sequence works in both builds.
module tb_flash_sample_streamer;

    localparam int AW = 23;

`ifdef STREAMER_DIV64_EN
    localparam logic [31:0] W0   = 32'h0080_0040;  // halves 0x40,0x80 -> 1,2
    localparam logic [31:0] W1   = 32'h0100_00C0;  // halves 0xC0,0x100 -> 3,4
    localparam logic [15:0] E_LO = 16'hFFFF;
    localparam logic [15:0] E_HI = 16'h0004;
`else
    localparam logic [31:0] W0   = 32'h0002_0001;
    localparam logic [31:0] W1   = 32'h0004_0003;
    localparam logic [15:0] E_LO = 16'hFFC0;
    localparam logic [15:0] E_HI = 16'h0100;
`endif
    localparam logic [31:0] WD = 32'h0100_FFC0;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [1:0]    mode;
    logic          busy;
    logic          done;
    logic          flash_mem_read;
    logic [AW-1:0] flash_mem_address;
    logic          flash_mem_burstcount;
    logic          flash_mem_waitrequest;
    logic [31:0]   flash_mem_readdata;
    logic          flash_mem_readdatavalid;
    logic          sample_valid;
    logic          sample_ready;
    logic [15:0]   sample_data;

    int compared   = 0;
    int mismatched = 0;
    int reads      = 0;
    int dones      = 0;
    int r0;
    int d0;

    flash_sample_streamer #(.FLASH_AW(AW), .SAMPLE_W(16), .NUM_WORDS(2)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .start                   (start),
        .mode                    (mode),
        .busy                    (busy),
        .done                    (done),
        .flash_mem_read          (flash_mem_read),
        .flash_mem_address       (flash_mem_address),
        .flash_mem_burstcount    (flash_mem_burstcount),
        .flash_mem_waitrequest   (flash_mem_waitrequest),
        .flash_mem_readdata      (flash_mem_readdata),
        .flash_mem_readdatavalid (flash_mem_readdatavalid),
        .sample_valid            (sample_valid),
        .sample_ready            (sample_ready),
        .sample_data             (sample_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (flash_mem_read && !flash_mem_waitrequest) reads++;
        if (done) dones++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_start(input logic [1:0] m);
        start = 1'b1;
        mode  = m;
        @(negedge clk);
        start = 1'b0;
        mode  = ~m;
        chk("busy_after_start", busy, 1);
        chk("first_read", flash_mem_read, 1);
    endtask

    task automatic serve_read(input logic [AW-1:0] addr, input logic [31:0] data, input int stalls);
        int n = 0;
        while (!flash_mem_read && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("read_seen", flash_mem_read, 1);
        chk("address", flash_mem_address, addr);
        for (int i = 0; i < stalls; i++) begin
            flash_mem_readdatavalid = (i == 0);
            flash_mem_readdata      = 32'hBAD0_BAD0;
            @(negedge clk);
            chk("read_held", flash_mem_read, 1);
            chk("addr_held", flash_mem_address, addr);
            chk("stray_rdv_ignored", sample_valid, 0);
        end
        flash_mem_readdatavalid = 1'b0;
        flash_mem_waitrequest   = 1'b0;
        @(negedge clk);
        flash_mem_waitrequest = 1'b1;
        chk("read_dropped", flash_mem_read, 0);
        flash_mem_readdatavalid = 1'b1;
        flash_mem_readdata      = data;
        @(negedge clk);
        flash_mem_readdatavalid = 1'b0;
        flash_mem_readdata      = 32'hDEAD_BEEF;
        chk("valid_latency", sample_valid, 1);
    endtask

    task automatic take_sample(input logic [15:0] exp, input int hold);
        int n = 0;
        while (!sample_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("sample_valid", sample_valid, 1);
        if (hold > 0) begin
            sample_ready = 1'b0;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk("stall_valid", sample_valid, 1);
                chk("stall_data", sample_data, exp);
            end
        end
        sample_ready = 1'b1;
        chk("sample_data", sample_data, exp);
        @(negedge clk);
    endtask

    // Called on the cycle after the last transfer; start is offered in the done cycle.
    task automatic check_done(input int exp_reads);
        chk("done_pulse", done, 1);
        chk("busy_in_fin", busy, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("done_one_cycle", done, 0);
        chk("busy_idle", busy, 0);
        @(negedge clk);
        chk("start_in_done_ignored", busy, 0);
        chk("no_read_in_idle", flash_mem_read, 0);
        chk("read_count", reads - r0, exp_reads);
        chk("done_count", dones - d0, 1);
    endtask

    initial begin
        rst                     = 1'b1;
        start                   = 1'b0;
        mode                    = 2'b00;
        flash_mem_waitrequest   = 1'b1;
        flash_mem_readdata      = 32'h0;
        flash_mem_readdatavalid = 1'b0;
        sample_ready            = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_read", flash_mem_read, 0);
        chk("rst_addr", flash_mem_address, 0);
        chk("rst_valid", sample_valid, 0);
        chk("rst_data", sample_data, 0);
        chk("rst_burst", flash_mem_burstcount, 1);
        rst = 1'b0;
        @(negedge clk);

        // normal mode
        r0 = reads; d0 = dones;
        do_start(2'b00);
        serve_read(0, W0, 0);
        take_sample(16'd1, 0);
        take_sample(16'd2, 0);
        serve_read(1, W1, 0);
        take_sample(16'd3, 0);
        take_sample(16'd4, 0);
        check_done(2);

        // fast mode; mode input flips to slow after start and must be ignored
        r0 = reads; d0 = dones;
        do_start(2'b01);
        serve_read(0, W0, 0);
        take_sample(16'd1, 0);
        serve_read(1, W1, 0);
        take_sample(16'd3, 0);
        check_done(2);

        // slow mode
        r0 = reads; d0 = dones;
        do_start(2'b10);
        serve_read(0, W0, 0);
        take_sample(16'd1, 0);
        take_sample(16'd1, 0);
        take_sample(16'd2, 0);
        take_sample(16'd2, 0);
        serve_read(1, W1, 0);
        take_sample(16'd3, 0);
        take_sample(16'd3, 0);
        take_sample(16'd4, 0);
        take_sample(16'd4, 0);
        check_done(2);

        // mode 11 behaves as normal; slave and consumer stalls; start while busy
        r0 = reads; d0 = dones;
        do_start(2'b11);
        start = 1'b1;
        serve_read(0, W0, 3);
        start = 1'b0;
        take_sample(16'd1, 4);
        take_sample(16'd2, 0);
        serve_read(1, W1, 0);
        take_sample(16'd3, 0);
        take_sample(16'd4, 2);
        check_done(2);

        // sign handling of the optional scaling
        r0 = reads; d0 = dones;
        do_start(2'b00);
        serve_read(0, WD, 0);
        take_sample(E_LO, 0);
        take_sample(E_HI, 0);
        serve_read(1, WD, 0);
        take_sample(E_LO, 0);
        take_sample(E_HI, 0);
        check_done(2);

        // reset while waiting for read data, then a late readdatavalid
        d0 = dones;
        do_start(2'b00);
        flash_mem_waitrequest = 1'b0;
        @(negedge clk);
        flash_mem_waitrequest = 1'b1;
        rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_read", flash_mem_read, 0);
        chk("arst_valid", sample_valid, 0);
        chk("arst_done", done, 0);
        chk("arst_addr", flash_mem_address, 0);
        chk("arst_data", sample_data, 0);
        @(negedge clk);
        rst                     = 1'b0;
        flash_mem_readdatavalid = 1'b1;
        flash_mem_readdata      = W1;
        @(negedge clk);
        flash_mem_readdatavalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("late_rdv_valid", sample_valid, 0);
            chk("late_rdv_busy", busy, 0);
            chk("late_rdv_read", flash_mem_read, 0);
            @(negedge clk);
        end
        chk("no_done_after_abort", dones - d0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/flash_sample_streamer.md
FLASH_SAMPLE_STREAMER -- requirements
Module: flash_sample_streamer

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- FLASH_AW, 23, flash word-address width.
- SAMPLE_W, 16, sample width; the block SHALL support only 16.
- NUM_WORDS, 2097152, 32-bit words streamed per run (1..2^FLASH_AW).

REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk  in  1  the only clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a run.
- mode  in  2  00 normal, 01 fast (chipmunk), 10 slow, 11 treated as normal.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of run.
- flash_mem_read  out  1  Avalon read request.
- flash_mem_address  out  FLASH_AW  word address.
- flash_mem_burstcount  out  1  constant 1.
- flash_mem_waitrequest  in  1  slave stall.
- flash_mem_readdata  in  32  read data.
- flash_mem_readdatavalid  in  1  read data qualifier.
- sample_valid  out  1  sample_data is valid.
- sample_ready  in  1  consumer accepts the sample.
- sample_data  out  SAMPLE_W  signed sample.

Function
REQ-003 States SHALL be IDLE, REQ, WAIT, EMIT_LO, EMIT_HI, FIN.
REQ-004 IDLE SHALL move to REQ on start=1, clearing word index w=0 and latching mode; mode changes during a run SHALL have no effect.
REQ-005 REQ SHALL drive flash_mem_read=1 and flash_mem_address=w, holding both until a cycle with waitrequest=0, then move to WAIT.
REQ-006 WAIT SHALL capture readdata on the first readdatavalid=1 and move to EMIT_LO; at most one read SHALL be outstanding at any time.
REQ-007 readdatavalid outside WAIT SHALL be ignored.
REQ-008 EMIT_LO SHALL present readdata[15:0], and EMIT_HI SHALL present readdata[31:16].
REQ-009 A sample SHALL transfer on sample_valid & sample_ready.
REQ-010 sample_data SHALL be held stable while sample_valid=1 and sample_ready=0.
REQ-011 Normal mode: each half SHALL be emitted once.
REQ-012 Fast mode: only the low half SHALL be emitted, and EMIT_HI SHALL be skipped.
REQ-013 Slow mode: each half SHALL be emitted twice, as two separate transfers.
REQ-014 After the last half of word w has transferred:
- if w < NUM_WORDS-1, w SHALL increment and the state SHALL return to REQ;
- otherwise the state SHALL go to FIN.
REQ-015 FIN SHALL pulse done=1 for exactly one cycle, then go to IDLE; busy SHALL be 0 in IDLE only.
REQ-016 start while busy=1 SHALL be ignored; start in the done cycle SHALL be ignored.
REQ-017 w SHALL NOT wrap; a run SHALL always end after exactly NUM_WORDS reads.
REQ-018 Latency: sample_valid SHALL rise on the cycle after readdatavalid is captured.
REQ-019 The first flash_mem_read SHALL assert on the cycle after start.

Reset
REQ-020 rst=1 SHALL asynchronously force state IDLE, w=0, and every output (busy, done, flash_mem_read, flash_mem_address, sample_valid, sample_data) to 0; flash_mem_burstcount SHALL remain 1.
REQ-021 rst asserted mid-run SHALL drop flash_mem_read immediately and abandon the run with no done pulse; the block SHALL discard any later readdatavalid.

Configuration
REQ-022 With macro STREAMER_DIV64_EN defined, sample_data SHALL equal the selected half arithmetically right-shifted by 6, sign-extended.
REQ-023 Without STREAMER_DIV64_EN, sample_data SHALL equal the selected half unmodified.

Verification
REQ-024 Normal, NUM_WORDS=2, flash word = 0x00020001 then 0x00040003, ready=1 -> samples 1,2,3,4, then one done pulse.
REQ-025 Fast mode, same data -> samples 1,3 only; exactly 2 reads issued.
REQ-026 Slow mode, word 0x00020001 -> samples 1,1,2,2.
REQ-027 Stalls: waitrequest=1 for 3 cycles -> read and address held 3 cycles; sample_ready=0 for 4 cycles -> sample_data unchanged, no sample lost.
REQ-028 rst pulse during WAIT, then a late readdatavalid -> all outputs 0, no sample emitted, no done pulse.
REQ-029 STREAMER_DIV64_EN defined, half 0xFFC0 (-64) -> 0xFFFF; half 0x0100 -> 0x0004.
